// File: rtl/uart_frame_tx.sv
// uart_frame_tx: 8-bit UART transmitter, LSB first, 1 start bit, 1 stop bit.
// Each bit is held for CLKS_PER_BIT clocks. All outputs are registered.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, an even
// parity bit is sent between the last data bit and the stop bit (8E1).
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Start,
    input  logic [7:0] Tx_Data,
    output logic       Tx_Out,
    output logic       Tx_Busy,
    output logic       Tx_Done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        STOP_BIT   = 3'd3,
        PARITY_BIT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic             tx_out_q, tx_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic bit_end;
    assign bit_end = (baud_cnt_q == LAST_CNT);

    // State and output registers; reset drops any frame and forces the line high.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Next-state logic: outputs are computed one cycle ahead so they leave registers.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        tx_out_d   = tx_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
                if (Tx_Start) begin
                    // Start bit appears on the accepting edge itself.
                    shift_d    = Tx_Data;
                    bit_cnt_d  = '0;
                    baud_cnt_d = '0;
                    tx_out_d   = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = START_BIT;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^Tx_Data;
`endif
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    tx_out_d   = shift_q[0];
                    state_d    = DATA_BITS;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_out_d = parity_q;
                        state_d  = PARITY_BIT;
`else
                        tx_out_d = 1'b1;
                        state_d  = STOP_BIT;
`endif
                    end else begin
                        // Next bit is what will sit at shift[0] after this shift.
                        tx_out_d = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    tx_out_d   = 1'b1;
                    state_d    = STOP_BIT;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP_BIT: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    tx_out_d   = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // Unused encodings fall back to an idle, high line.
                state_d    = IDLE;
                tx_out_d   = 1'b1;
                busy_d     = 1'b0;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    assign Tx_Out  = tx_out_q;
    assign Tx_Busy = busy_q;
    assign Tx_Done = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx with CLKS_PER_BIT=4. Follows UART_TX_PARITY_EN
// so the same bench covers both the 8N1 and 8E1 builds.
module tb_uart_frame_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Tx_Start = 1'b0;
    logic [7:0] Tx_Data = 8'h00;
    logic       Tx_Out;
    logic       Tx_Busy;
    logic       Tx_Done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_frame_tx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (16)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Tx_Start(Tx_Start),
        .Tx_Data (Tx_Data),
        .Tx_Out  (Tx_Out),
        .Tx_Busy (Tx_Busy),
        .Tx_Done (Tx_Done)
    );

    always #5 Clk = ~Clk;

    // Known-answer table: line bits in time order (bit 0 = start bit) for 8N1,
    // plus the hand-computed even parity bit.
    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
        logic       par;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int got, input int expv);
        total_cnt++;
        if (got == expv) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    endtask

    // Reference frame from the framing rules: start 0, data LSB first,
    // optional even parity, stop 1.
    function automatic logic [10:0] model_line(input logic [7:0] d);
        logic [10:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = ((int'(d) / (1 << i)) % 2) == 1;
`ifdef UART_TX_PARITY_EN
        b[9] = ($countones(d) % 2) == 1;
`endif
        return b;
    endfunction

    function automatic logic [10:0] table_line(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return {1'b1, v.par, v.line[8:0]};
`else
        return {1'b0, v.line};
`endif
    endfunction

    // Send one byte and compare the line cycle by cycle; optionally fire a
    // stray Tx_Start (data FF) at frame cycle ignore_at.
    task automatic run_frame(input logic [7:0] d, input logic [10:0] exp_line,
                             input string name, input int ignore_at);
        int line_err = 0;
        int busy_err = 0;
        int done_err = 0;
        @(negedge Clk);
        Tx_Start = 1'b1;
        Tx_Data  = d;
        @(negedge Clk);
        Tx_Start = 1'b0;
        Tx_Data  = 8'($urandom);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge Clk);
            if (k == ignore_at) begin
                Tx_Start = 1'b1;
                Tx_Data  = 8'hFF;
            end else if (k == ignore_at + 1) begin
                Tx_Start = 1'b0;
            end
            if (Tx_Out !== exp_line[k / CPB]) line_err++;
            if (Tx_Busy !== 1'b1) busy_err++;
            if (Tx_Done !== 1'b0) done_err++;
        end
        check({name, " line_bad_cycles"}, line_err, 0);
        check({name, " busy_low_cycles"}, busy_err, 0);
        check({name, " early_done_cycles"}, done_err, 0);
        @(negedge Clk);
        check({name, " done_pulse{done,busy,out}"}, int'({Tx_Done, Tx_Busy, Tx_Out}), 5);
        @(negedge Clk);
        check({name, " done_cleared"}, int'(Tx_Done), 0);
        $display("frame %s data=%02h line_errs=%0d busy_errs=%0d", name, d, line_err, busy_err);
    endtask

    logic rec[128];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int starts[$];
        logic [7:0] bytes_q[$];
        int stop_bad;
        int dones;
        int len;
        int i;
        logic [7:0] rd;
        logic [7:0] rnd;

        vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
        vecs[1] = '{8'h3C, 10'b1001111000, 1'b0};
        vecs[2] = '{8'h07, 10'b1000001110, 1'b1};
        vecs[3] = '{8'h03, 10'b1000000110, 1'b0};
        vecs[4] = '{8'h00, 10'b1000000000, 1'b0};
        vecs[5] = '{8'hFF, 10'b1111111110, 1'b0};
        vecs[6] = '{8'h81, 10'b1100000010, 1'b0};

        // Reset held for two cycles, then ten idle cycles.
        repeat (2) @(negedge Clk);
        check("reset {out,busy,done}", int'({Tx_Out, Tx_Busy, Tx_Done}), 4);
        Rst = 1'b1;
        errs = 0;
        repeat (10) begin
            @(negedge Clk);
            if (Tx_Out !== 1'b1 || Tx_Busy !== 1'b0 || Tx_Done !== 1'b0) errs++;
        end
        check("idle_after_reset bad_cycles", errs, 0);
        $display("reset sequence done");

        // Known-answer frames.
        for (int v = 0; v < 7; v++)
            run_frame(vecs[v].data, table_line(vecs[v]), $sformatf("table%0d", v), -1);

        // Busy ignore: stray strobe with FF at cycle 12 must not alter or queue.
        run_frame(8'h3C, table_line(vecs[1]), "busy_ignore", 12);
        errs = 0;
        dones = 0;
        repeat (2 * FRAME) begin
            @(negedge Clk);
            if (Tx_Out !== 1'b1) errs++;
            if (Tx_Done === 1'b1) dones++;
        end
        check("busy_ignore extra_low_cycles", errs, 0);
        check("busy_ignore extra_dones", dones, 0);
        $display("busy_ignore tail low=%0d dones=%0d", errs, dones);

        // Back-to-back with Tx_Start held: 00 then FF. The done cycle is the
        // idle cycle that accepts the next strobe, so starts are FRAME+1 apart.
        len = 2 * FRAME + 8;
        @(negedge Clk);
        Tx_Start = 1'b1;
        Tx_Data  = 8'h00;
        dones = 0;
        for (int k = 0; k < len; k++) begin
            @(negedge Clk);
            if (k == 0) Tx_Data = 8'hFF;
            if (k == FRAME + 1) Tx_Start = 1'b0;
            rec[k] = Tx_Out;
            if (Tx_Done === 1'b1) dones++;
        end
        stop_bad = 0;
        i = 0;
        while (i < len) begin
            if (rec[i] == 1'b0 && i + CPB * NB <= len) begin
                rd = '0;
                for (int b = 0; b < 8; b++) rd[b] = rec[i + CPB * (b + 1) + CPB / 2];
                if (rec[i + CPB * (NB - 1) + CPB / 2] !== 1'b1) stop_bad++;
                starts.push_back(i);
                bytes_q.push_back(rd);
                i = i + CPB * NB;
            end else begin
                i++;
            end
        end
        check("b2b frames_seen", starts.size(), 2);
        if (starts.size() == 2) begin
            check("b2b byte0", int'(bytes_q[0]), 8'h00);
            check("b2b byte1", int'(bytes_q[1]), 8'hFF);
            check("b2b start_spacing", starts[1] - starts[0], FRAME + 1);
        end
        check("b2b stop_bits_bad", stop_bad, 0);
        check("b2b done_count", dones, 2);
        $display("back_to_back frames=%0d dones=%0d", starts.size(), dones);

        // Mid-frame asynchronous reset during data bit 3 of 00.
        @(negedge Clk);
        Tx_Start = 1'b1;
        Tx_Data  = 8'h00;
        @(negedge Clk);
        Tx_Start = 1'b0;
        repeat (17) @(negedge Clk);
        check("midreset line_before", int'(Tx_Out), 0);
        #2 Rst = 1'b0;
        #1;
        check("midreset immediate {out,busy,done}", int'({Tx_Out, Tx_Busy, Tx_Done}), 4);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        errs = 0;
        repeat (3) begin
            @(negedge Clk);
            if (Tx_Out !== 1'b1 || Tx_Busy !== 1'b0) errs++;
        end
        check("midreset idle_after bad_cycles", errs, 0);
        $display("mid_frame_reset done");
        run_frame(8'h81, table_line(vecs[6]), "after_reset", -1);

        // Random bytes against the framing model, with random idle gaps.
        for (int r = 0; r < 10; r++) begin
            rnd = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge Clk);
            run_frame(rnd, model_line(rnd), $sformatf("rand%0d", r), -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
